// File: rtl/uart_param_if.sv
// Word-level handshake bundle for uart_param: TX ready/valid in, RX FIFO head out.
// master is the client logic, slave is the UART.
interface uart_param_if #(parameter int DATA_BITS = 8);
    logic                 tx_valid;
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_ready;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_perr;
    logic                 rx_valid;
    logic                 rx_ready;

    modport master (output tx_valid, tx_data, rx_ready,
                    input  tx_ready, rx_data, rx_perr, rx_valid);
    modport slave  (input  tx_valid, tx_data, rx_ready,
                    output tx_ready, rx_data, rx_perr, rx_valid);
endinterface

// File: rtl/uart_param.sv
// Parametrised full-duplex UART: configurable width/parity/stop bits, start-glitch
// rejection, 2-flop RX synchroniser and an RX FIFO with parity flag per word.
module uart_param #(
    parameter int CLK_DIV   = 434,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1,
    parameter int RX_DEPTH  = 4
) (
    input  logic        clk,
    input  logic        nRst,
    uart_param_if.slave bus,
    output logic        tx,
    input  logic        rx,
    output logic        rx_frame_err,
    output logic        rx_overrun,
    output logic        busy_rx
);
    localparam int CW  = $clog2(CLK_DIV);
    localparam int AW  = $clog2(RX_DEPTH);
    localparam int AW1 = AW + 1;
    localparam logic [CW-1:0]  BIT_END  = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0]  HALF     = CW'(CLK_DIV / 2);
    localparam logic [AW1-1:0] FULL_CNT = AW1'(RX_DEPTH);
    localparam logic           ODD      = (PARITY == 1);

    // ---------------- TX ----------------
    typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PAR, TX_STOP} tx_state_t;
    tx_state_t            tx_st;
    logic [CW-1:0]        tx_cnt;
    logic [3:0]           tx_bit;
    logic [DATA_BITS-1:0] tx_shr;
    logic                 tx_par, tx_q, tx_rdy;

    always_ff @(posedge clk) begin
        if (!nRst) begin
            tx_st  <= TX_IDLE;
            tx_cnt <= '0;
            tx_bit <= '0;
            tx_shr <= '0;
            tx_par <= 1'b0;
            tx_q   <= 1'b1;
            tx_rdy <= 1'b0;
        end else if (tx_st == TX_IDLE) begin
            tx_q   <= 1'b1;
            tx_rdy <= 1'b1;
            if (bus.tx_valid && tx_rdy) begin
                tx_shr <= bus.tx_data;
                tx_par <= ^bus.tx_data ^ ODD;
                tx_q   <= 1'b0;
                tx_rdy <= 1'b0;
                tx_cnt <= '0;
                tx_st  <= TX_START;
            end
        end else if (tx_cnt != BIT_END) begin
            tx_cnt <= tx_cnt + 1'b1;
        end else begin
            tx_cnt <= '0;
            case (tx_st)
                TX_START: begin
                    tx_q   <= tx_shr[0];
                    tx_shr <= tx_shr >> 1;
                    tx_bit <= '0;
                    tx_st  <= TX_DATA;
                end
                TX_DATA: begin
                    if (tx_bit == 4'(DATA_BITS - 1)) begin
                        tx_bit <= '0;
                        if (PARITY != 0) begin
                            tx_q  <= tx_par;
                            tx_st <= TX_PAR;
                        end else begin
                            tx_q  <= 1'b1;
                            tx_st <= TX_STOP;
                        end
                    end else begin
                        tx_q   <= tx_shr[0];
                        tx_shr <= tx_shr >> 1;
                        tx_bit <= tx_bit + 1'b1;
                    end
                end
                TX_PAR: begin
                    tx_q  <= 1'b1;
                    tx_st <= TX_STOP;
                end
                TX_STOP: begin
                    if (tx_bit == 4'(STOP_BITS - 1)) begin
                        tx_st  <= TX_IDLE;
                        tx_rdy <= 1'b1;
                    end else begin
                        tx_bit <= tx_bit + 1'b1;
                    end
                end
                default: tx_st <= TX_IDLE;
            endcase
        end
    end

    assign tx           = tx_q;
    assign bus.tx_ready = tx_rdy;

    // ---------------- RX ----------------
    logic rx_s1, rxs;
    always_ff @(posedge clk) begin
        if (!nRst) begin
            rx_s1 <= 1'b1;
            rxs   <= 1'b1;
        end else begin
            rx_s1 <= rx;
            rxs   <= rx_s1;
        end
    end

    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PAR, RX_STOP, RX_WAIT} rx_state_t;
    rx_state_t            rx_st;
    logic [CW-1:0]        rx_cnt;
    logic [3:0]           rx_bit;
    logic [DATA_BITS-1:0] rx_shr;
    logic                 rx_perr_q, busy_q, ferr_q, push_q;

    // After the start-bit midpoint the counter restarts, so every later sample is mid-bit.
    always_ff @(posedge clk) begin
        if (!nRst) begin
            rx_st     <= RX_IDLE;
            rx_cnt    <= '0;
            rx_bit    <= '0;
            rx_shr    <= '0;
            rx_perr_q <= 1'b0;
            busy_q    <= 1'b0;
            ferr_q    <= 1'b0;
            push_q    <= 1'b0;
        end else begin
            ferr_q <= 1'b0;
            push_q <= 1'b0;
            case (rx_st)
                RX_IDLE: begin
                    if (!rxs) begin
                        rx_st     <= RX_START;
                        rx_cnt    <= '0;
                        busy_q    <= 1'b1;
                        rx_perr_q <= 1'b0;
                    end
                end
                RX_START: begin
                    if (rx_cnt != HALF) begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end else if (rxs) begin
                        rx_st  <= RX_IDLE;
                        busy_q <= 1'b0;
                    end else begin
                        rx_cnt <= '0;
                        rx_bit <= '0;
                        rx_st  <= RX_DATA;
                    end
                end
                RX_DATA: begin
                    if (rx_cnt != BIT_END) begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end else begin
                        rx_cnt <= '0;
                        rx_shr <= {rxs, rx_shr[DATA_BITS-1:1]};
                        if (rx_bit == 4'(DATA_BITS - 1))
                            rx_st <= (PARITY != 0) ? RX_PAR : RX_STOP;
                        else
                            rx_bit <= rx_bit + 1'b1;
                    end
                end
                RX_PAR: begin
                    if (rx_cnt != BIT_END) begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end else begin
                        rx_cnt    <= '0;
                        rx_perr_q <= rxs ^ (^rx_shr) ^ ODD;
                        rx_st     <= RX_STOP;
                    end
                end
                RX_STOP: begin
                    if (rx_cnt != BIT_END) begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end else begin
                        rx_cnt <= '0;
                        if (rxs) begin
                            push_q <= 1'b1;
                            busy_q <= 1'b0;
                            rx_st  <= RX_IDLE;
                        end else begin
                            ferr_q <= 1'b1;
                            rx_st  <= RX_WAIT;
                        end
                    end
                end
                RX_WAIT: begin
                    if (rxs) begin
                        rx_st  <= RX_IDLE;
                        busy_q <= 1'b0;
                    end
                end
                default: rx_st <= RX_IDLE;
            endcase
        end
    end

    assign rx_frame_err = ferr_q;
    assign busy_rx      = busy_q;

    // ---------------- RX FIFO ----------------
    logic [DATA_BITS:0] mem [RX_DEPTH];
    logic [AW-1:0]      wr_ptr, rd_ptr;
    logic [AW1-1:0]     count;
    logic               ovr_q, pop, full, do_push;

    assign pop     = bus.rx_valid & bus.rx_ready;
    assign full    = (count == FULL_CNT);
    assign do_push = push_q & (~full | pop);

    always_ff @(posedge clk) begin
        if (nRst && do_push)
            mem[wr_ptr] <= {rx_perr_q, rx_shr};
    end

    always_ff @(posedge clk) begin
        if (!nRst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovr_q  <= 1'b0;
        end else begin
            ovr_q <= push_q & full & ~pop;
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign rx_overrun   = ovr_q;
    assign bus.rx_valid = (count != '0);
    assign bus.rx_data  = bus.rx_valid ? mem[rd_ptr][DATA_BITS-1:0] : '0;
    assign bus.rx_perr  = bus.rx_valid & mem[rd_ptr][DATA_BITS];
endmodule

// File: tb/tb_uart_param.sv
// Directed bench for uart_param: four configurations (8N1, 8E1 loopback, 8O1, 7N2), CLK_DIV = 16.
module tb_uart_param;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic nRst;
    logic rxa, rxc, rxd;
    logic txa, txb, txc, txd;
    logic ferr_a, ovr_a, busy_a, ferr_b, ovr_b, busy_b;
    logic ferr_c, ovr_c, busy_c, ferr_d, ovr_d, busy_d;
    int checks = 0, errors = 0;
    int ovr_cnt_a = 0, ferr_cnt_c = 0;

    uart_param_if #(.DATA_BITS(8)) ifa ();
    uart_param_if #(.DATA_BITS(8)) ifb ();
    uart_param_if #(.DATA_BITS(8)) ifc ();
    uart_param_if #(.DATA_BITS(7)) ifd ();

    uart_param #(.CLK_DIV(16), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .RX_DEPTH(4)) dut_a (
        .clk(clk), .nRst(nRst), .bus(ifa), .tx(txa), .rx(rxa),
        .rx_frame_err(ferr_a), .rx_overrun(ovr_a), .busy_rx(busy_a));
    uart_param #(.CLK_DIV(16), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .RX_DEPTH(4)) dut_b (
        .clk(clk), .nRst(nRst), .bus(ifb), .tx(txb), .rx(txb),
        .rx_frame_err(ferr_b), .rx_overrun(ovr_b), .busy_rx(busy_b));
    uart_param #(.CLK_DIV(16), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .RX_DEPTH(4)) dut_c (
        .clk(clk), .nRst(nRst), .bus(ifc), .tx(txc), .rx(rxc),
        .rx_frame_err(ferr_c), .rx_overrun(ovr_c), .busy_rx(busy_c));
    uart_param #(.CLK_DIV(16), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2), .RX_DEPTH(4)) dut_d (
        .clk(clk), .nRst(nRst), .bus(ifd), .tx(txd), .rx(rxd),
        .rx_frame_err(ferr_d), .rx_overrun(ovr_d), .busy_rx(busy_d));

    always @(posedge clk) begin
        if (ovr_a)  ovr_cnt_a  <= ovr_cnt_a + 1;
        if (ferr_c) ferr_cnt_c <= ferr_cnt_c + 1;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    typedef struct { logic [7:0] data; logic [9:0] frame; } tx_vec_t;
    typedef struct { logic [7:0] data; logic par; logic stop; logic push; logic perr; logic ferr; } rx_vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    function automatic logic get_tx(input int s);
        case (s) 0: return txa; 1: return txb; 2: return txc; default: return txd; endcase
    endfunction
    function automatic logic get_rdy(input int s);
        case (s) 0: return ifa.tx_ready; 1: return ifb.tx_ready; 2: return ifc.tx_ready; default: return ifd.tx_ready; endcase
    endfunction
    function automatic logic get_valid(input int s);
        case (s) 0: return ifa.rx_valid; 1: return ifb.rx_valid; 2: return ifc.rx_valid; default: return ifd.rx_valid; endcase
    endfunction
    function automatic logic get_perr(input int s);
        case (s) 0: return ifa.rx_perr; 1: return ifb.rx_perr; 2: return ifc.rx_perr; default: return ifd.rx_perr; endcase
    endfunction
    function automatic logic [7:0] get_data(input int s);
        case (s) 0: return ifa.rx_data; 1: return ifb.rx_data; 2: return ifc.rx_data; default: return {1'b0, ifd.rx_data}; endcase
    endfunction

    task automatic set_line(input int s, input logic v);
        case (s) 0: rxa = v; 2: rxc = v; default: rxd = v; endcase
    endtask
    task automatic set_rxready(input int s, input logic v);
        case (s) 0: ifa.rx_ready = v; 1: ifb.rx_ready = v; 2: ifc.rx_ready = v; default: ifd.rx_ready = v; endcase
    endtask
    task automatic set_tx(input int s, input logic v, input logic [7:0] d);
        case (s)
            0: begin ifa.tx_valid = v; ifa.tx_data = d; end
            1: begin ifb.tx_valid = v; ifb.tx_data = d; end
            2: begin ifc.tx_valid = v; ifc.tx_data = d; end
            default: begin ifd.tx_valid = v; ifd.tx_data = d[6:0]; end
        endcase
    endtask

    task automatic wait_ready(input int s, input string name);
        int n = 0;
        while (!get_rdy(s) && n < 400) begin @(negedge clk); n++; end
        chk(name, get_rdy(s), 1);
    endtask

    // Returns at the negedge of cycle 1 after the handshake edge; tx_data is scrambled.
    task automatic tx_send(input int s, input logic [7:0] d);
        wait_ready(s, "tx_ready before send");
        set_tx(s, 1'b1, d);
        @(negedge clk);
        set_tx(s, 1'b0, ~d);
    endtask

    task automatic drive_line(input int s, input logic [15:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            set_line(s, bits[i]);
            repeat (16) @(negedge clk);
        end
    endtask

    task automatic pop_check(input int s, input logic [7:0] d, input logic p, input string name);
        chk({name, " valid"}, get_valid(s), 1);
        chk({name, " data"}, get_data(s), d);
        chk({name, " perr"}, get_perr(s), p);
        set_rxready(s, 1'b1);
        @(negedge clk);
        set_rxready(s, 1'b0);
    endtask

    // Called at cycle 1 after the handshake on instance A.
    task automatic check_tx_frame(input logic [9:0] f, input string name);
        for (int k = 1; k <= 161; k++) begin
            if (k <= 160) chk($sformatf("%s tx@%0d", name, k), txa, f[(k-1)/16]);
            if (k == 160) chk({name, " ready low@160"}, ifa.tx_ready, 0);
            if (k == 161) chk({name, " ready@161"}, ifa.tx_ready, 1);
            if (k < 161) @(negedge clk);
        end
    endtask

    tx_vec_t tv [4];
    rx_vec_t rv [5];

    initial begin
        int o0;
        logic [7:0] b;
        logic [15:0] rf;

        tv[0] = '{8'hA5, 10'b1101001010};
        tv[1] = '{8'h00, 10'b1000000000};
        tv[2] = '{8'hFF, 10'b1111111110};
        tv[3] = '{8'h01, 10'b1000000010};
        // 8O1 frames: data, parity bit on the wire, stop bit, expected push/perr/frame_err
        rv[0] = '{8'h55, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        rv[1] = '{8'h55, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        rv[2] = '{8'h01, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        rv[3] = '{8'hFF, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        rv[4] = '{8'h3C, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

        nRst = 1'b0;
        rxa = 1'b1; rxc = 1'b1; rxd = 1'b1;
        for (int s = 0; s < 4; s++) begin set_tx(s, 1'b0, 8'h00); set_rxready(s, 1'b0); end
        repeat (3) @(negedge clk);
        for (int s = 0; s < 4; s++) begin
            chk($sformatf("reset tx[%0d]", s), get_tx(s), 1);
            chk($sformatf("reset tx_ready[%0d]", s), get_rdy(s), 0);
            chk($sformatf("reset rx_valid[%0d]", s), get_valid(s), 0);
            chk($sformatf("reset rx_data[%0d]", s), get_data(s), 0);
            chk($sformatf("reset rx_perr[%0d]", s), get_perr(s), 0);
        end
        chk("reset flags", {ferr_a, ovr_a, busy_a, ferr_b, ovr_b, busy_b,
                            ferr_c, ovr_c, busy_c, ferr_d, ovr_d, busy_d}, 0);
        nRst = 1'b1;
        @(negedge clk);
        for (int s = 0; s < 4; s++) chk($sformatf("tx_ready after reset[%0d]", s), get_rdy(s), 1);

        // 8N1 TX framing and timing
        for (int i = 0; i < 4; i++) begin
            tx_send(0, tv[i].data);
            check_tx_frame(tv[i].frame, $sformatf("8N1 tx %0h", tv[i].data));
        end

        // 8E1 loopback
        tx_send(1, 8'h03);
        repeat (151) @(negedge clk);
        chk("8E1 parity bit 0x03", txb, 0);
        tx_send(1, 8'h07);
        repeat (151) @(negedge clk);
        chk("8E1 parity bit 0x07", txb, 1);
        wait_ready(1, "8E1 ready after 0x07");
        repeat (30) @(negedge clk);
        pop_check(1, 8'h03, 1'b0, "loopback 0x03");
        pop_check(1, 8'h07, 1'b0, "loopback 0x07");
        chk("loopback empty", ifb.rx_valid, 0);

        // 8O1 RX vectors: parity and framing errors
        for (int i = 0; i < 5; i++) begin
            int f0;
            f0 = ferr_cnt_c;
            drive_line(2, {5'b0, rv[i].stop, rv[i].par, rv[i].data, 1'b0}, 11);
            if (!rv[i].stop) begin
                repeat (20) @(negedge clk);
                chk($sformatf("8O1[%0d] busy held on low line", i), busy_c, 1);
            end
            rxc = 1'b1;
            repeat (6) @(negedge clk);
            chk($sformatf("8O1[%0d] busy idle", i), busy_c, 0);
            chk($sformatf("8O1[%0d] frame_err pulses", i), ferr_cnt_c - f0, {31'b0, rv[i].ferr});
            if (rv[i].push) pop_check(2, rv[i].data, rv[i].perr, $sformatf("8O1[%0d]", i));
            chk($sformatf("8O1[%0d] fifo empty", i), ifc.rx_valid, 0);
        end

        // start-bit glitch on A, then 7N2 on D
        rxa = 1'b0;
        repeat (5) @(negedge clk);
        chk("glitch busy rises", busy_a, 1);
        rxa = 1'b1;
        repeat (20) @(negedge clk);
        chk("glitch busy drops", busy_a, 0);
        chk("glitch nothing pushed", ifa.rx_valid, 0);
        drive_line(3, {6'b0, 2'b11, 7'h7F, 1'b0}, 10);
        repeat (10) @(negedge clk);
        pop_check(3, 8'h7F, 1'b0, "7N2 0x7F");

        // overrun: five frames into a 4-deep FIFO with no pops
        for (int i = 0; i < 5; i++) begin
            o0 = ovr_cnt_a;
            b = 8'(8'h11 + i);
            drive_line(0, {6'b0, 1'b1, b, 1'b0}, 10);
            repeat (4) @(negedge clk);
            chk($sformatf("overrun pulses frame %0d", i), ovr_cnt_a - o0, (i == 4) ? 1 : 0);
        end
        for (int i = 0; i < 4; i++) begin
            b = 8'(8'h11 + i);
            pop_check(0, b, 1'b0, $sformatf("overrun pop %0d", i));
        end
        chk("overrun fifo drained", ifa.rx_valid, 0);

        // pop coinciding with the fifth push
        for (int i = 0; i < 4; i++) begin
            b = 8'(8'h11 + i);
            drive_line(0, {6'b0, 1'b1, b, 1'b0}, 10);
        end
        repeat (4) @(negedge clk);
        o0 = ovr_cnt_a;
        fork
            drive_line(0, {6'b0, 1'b1, 8'h15, 1'b0}, 10);
            begin
                logic prev, done;
                int n;
                prev = busy_a; done = 1'b0; n = 0;
                while (n < 300 && !done) begin
                    @(negedge clk);
                    n++;
                    if (prev && !busy_a) begin
                        chk("coincident pop head", ifa.rx_data, 8'h11);
                        ifa.rx_ready = 1'b1;
                        @(negedge clk);
                        ifa.rx_ready = 1'b0;
                        done = 1'b1;
                    end
                    prev = busy_a;
                end
                chk("coincident pop happened", done, 1);
            end
        join
        repeat (4) @(negedge clk);
        chk("coincident no overrun", ovr_cnt_a - o0, 0);
        for (int i = 0; i < 4; i++) begin
            b = 8'(8'h12 + i);
            pop_check(0, b, 1'b0, $sformatf("coincident pop %0d", i));
        end
        chk("coincident fifo drained", ifa.rx_valid, 0);

        // reset during TX bit 3 / RX data bit 4 with a word already queued
        drive_line(0, {6'b0, 1'b1, 8'h5A, 1'b0}, 10);
        repeat (4) @(negedge clk);
        chk("preload queued", ifa.rx_valid, 1);
        chk("ready before reset test", ifa.tx_ready, 1);
        rf = {6'b0, 1'b1, 8'h96, 1'b0};
        for (int c = 0; c <= 82; c++) begin
            rxa = rf[c/16];
            ifa.tx_valid = (c == 10);
            ifa.tx_data = 8'hA5;
            if (c == 82) nRst = 1'b0;
            @(negedge clk);
        end
        rxa = 1'b1;
        chk("midreset tx", txa, 1);
        chk("midreset rx_valid", ifa.rx_valid, 0);
        chk("midreset busy_rx", busy_a, 0);
        nRst = 1'b1;
        @(negedge clk);
        chk("midreset tx_ready", ifa.tx_ready, 1);
        chk("midreset tx idle", txa, 1);
        tx_send(0, 8'h3C);
        check_tx_frame(10'b1001111000, "post-reset tx 3c");
        drive_line(0, {6'b0, 1'b1, 8'h3C, 1'b0}, 10);
        repeat (4) @(negedge clk);
        pop_check(0, 8'h3C, 1'b0, "post-reset rx 3c");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_param.md
Name: uart_param

Overview:
- Parametrised full-duplex UART; next-generation serial link between host PC and FPGA logic.
- Adds configurable data width, optional parity, 1 or 2 stop bits and an RX FIFO with ready/valid on both sides.
- Adds start-bit glitch rejection, a metastability synchroniser, and frame/parity/overrun error reporting.

Parameters:
- CLK_DIV, 434, clock cycles per bit (50 MHz / 115200); legal 4..65535.
- DATA_BITS, 8, data bits per frame; legal 5..9.
- PARITY, 0, 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1, 1 or 2.
- RX_DEPTH, 4, RX FIFO entries; power of two, 2..64.

Ports:
- clk  in  1  system clock
- nRst  in  1  synchronous active-low reset
- tx_valid  in  1  TX word offered
- tx_data  in  DATA_BITS  TX word
- tx_ready  out  1  TX accepts word (idle)
- tx  out  1  serial out, idle high
- rx  in  1  serial in, asynchronous
- rx_data  out  DATA_BITS  head-of-FIFO word
- rx_perr  out  1  parity error flag stored with head word
- rx_valid  out  1  FIFO not empty
- rx_ready  in  1  consumer pops head word
- rx_frame_err  out  1  1-cycle pulse, stop bit sampled low
- rx_overrun  out  1  1-cycle pulse, word dropped because FIFO full
- busy_rx  out  1  RX frame in progress

Behaviour:
- Reset is synchronous to the clk rising edge while nRst = 0. Reset values:
  - tx = 1, tx_ready = 0 during reset, 1 on the first cycle after.
  - rx_valid, rx_perr, rx_frame_err, rx_overrun, busy_rx = 0; rx_data = 0.
  - FIFO emptied; both FSMs to IDLE; synchroniser flops = 1.
- Reset mid-frame aborts both directions immediately; no partial word is pushed.
- Bit timer: counter 0..CLK_DIV-1, so one bit lasts exactly CLK_DIV cycles. Width is clog2(CLK_DIV).
- Bit order is LSB first on both TX and RX.
- Parity bit = XOR of data bits for even parity, inverted for odd parity.
- TX FSM: IDLE -> START -> DATA(DATA_BITS) -> PARITY (skipped if PARITY = 0) -> STOP(STOP_BITS) -> IDLE.
  - Handshake occurs when tx_valid & tx_ready. The word is latched and tx_ready drops the next cycle.
  - tx goes low on the cycle after the handshake; each bit is held CLK_DIV cycles.
  - tx_ready rises on the cycle after the last stop bit completes.
  - Handshake-to-ready = 1 + (1 + DATA_BITS + (PARITY != 0) + STOP_BITS) * CLK_DIV cycles.
  - tx_data is ignored while tx_ready = 0.
- RX path: rx passes through a 2-flop synchroniser (rxs); FSM latency from the pin is 2 cycles.
- RX FSM: IDLE -> START -> DATA -> PARITY (optional) -> STOP -> IDLE.
  - IDLE: on rxs = 0, go to START, counter = 0, busy_rx = 1.
  - START: at count CLK_DIV/2 (integer divide), rxs = 1 means a glitch: return to IDLE, busy_rx = 0, nothing pushed. Otherwise counter restarts and subsequent samples are taken every CLK_DIV cycles (mid-bit).
  - DATA: shift in DATA_BITS samples LSB first.
  - PARITY: sample and compare; mismatch sets the stored perr bit.
  - STOP: sample the first stop bit only. The second stop bit is not checked on RX.
    - rxs = 1: push {perr, data}, go to IDLE, busy_rx = 0.
    - rxs = 0: pulse rx_frame_err, discard word, go to WAIT.
  - WAIT: stay until rxs = 1, then IDLE with busy_rx = 0.
- FIFO: RX_DEPTH entries of DATA_BITS + 1 bits; rd/wr pointers plus a count.
  - rx_data and rx_perr show the head entry combinationally; rx_valid = (count != 0).
  - Pop occurs when rx_valid & rx_ready.
  - Push when full with no pop: word dropped, rx_overrun pulses 1 cycle, FIFO contents unchanged.
  - Push when full with a pop in the same cycle: both happen, no overrun, count unchanged.
  - Push when empty: rx_valid rises the next cycle (no same-cycle bypass).
  - Pointers wrap modulo RX_DEPTH.
- TX and RX are independent; simultaneous activity is legal. Loopback (tx tied to rx) must work.

Test Plan:
- 8N1, CLK_DIV = 16: send 0xA5 -> tx low for cycles 1..16 after handshake, then bits 1,0,1,0,0,1,0,1 at 16 cycles each, then high for 16 cycles; tx_ready returns at cycle 161.
- 8E1 loopback, CLK_DIV = 16: send 0x03 then 0x07 -> parity bits 0 then 1; RX pops 0x03 then 0x07 with rx_perr = 0 for both.
- Errors, 8O1: drive a frame 0x55 with a wrong parity bit -> popped as 0x55, rx_perr = 1. Drive a frame with stop = 0 -> rx_frame_err pulses once, FIFO unchanged, busy_rx stays high until the line returns high.
- Overrun, RX_DEPTH = 4, rx_ready = 0: receive 0x11..0x15 -> rx_overrun pulses on the fifth; pops return 0x11..0x14. Repeat with a pop coinciding with the fifth push -> no overrun, 0x15 retained.
- Glitch, CLK_DIV = 16: rx low for 5 cycles -> busy_rx returns low, nothing pushed. Then a 7N2 config receiving 0x7F -> rx_data = 0x7F.
- Reset mid-frame: assert nRst = 0 for one cycle during TX bit 3 and RX bit 4 -> next cycle tx = 1, tx_ready = 1, rx_valid = 0, busy_rx = 0. A subsequent 0x3C transfers correctly.
